// File: rtl/framed_payload_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module   : framed_payload_sender_pkg
// Brief    : Shared state encoding and width helpers for the framed sender.
// Revision : 1.0 - initial release
// ============================================================================
package framed_payload_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Byte index width for a frame of 'total' bytes (never below 1 bit).
  function automatic int idx_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/framed_payload_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : framed_payload_sender_if
// Brief    : Request/payload/UART handshake bundle of the framed sender.
// Revision : 1.0 - initial release
// ============================================================================
interface framed_payload_sender_if #(
  parameter int SEND_BYTES_QTD = 2
);

  logic                          habilitar_envio;
  logic                          uart_ocupado;
  logic [8*SEND_BYTES_QTD-1:0]   buffer_envio;
  logic                          iniciar_envio;
  logic [7:0]                    dado_saida;
  logic                          envio_concluido;
  logic                          ocupado;

  modport master (
    output habilitar_envio, uart_ocupado, buffer_envio,
    input  iniciar_envio, dado_saida, envio_concluido, ocupado
  );

  modport slave (
    input  habilitar_envio, uart_ocupado, buffer_envio,
    output iniciar_envio, dado_saida, envio_concluido, ocupado
  );

endinterface
`default_nettype wire

// File: rtl/framed_payload_sender_uart_byte_handshake.sv
`default_nettype none
// ============================================================================
// Module   : framed_payload_sender_uart_byte_handshake
// Brief    : Hands one byte to the UART with start/busy handshake and retry.
// Revision : 1.0 - initial release
// ============================================================================
module framed_payload_sender_uart_byte_handshake
  import framed_payload_sender_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] byte_in,
  input  logic       uart_ocupado,
  output logic       iniciar_envio,
  output logic [7:0] dado_saida,
  output logic       byte_done
);

  localparam int                c_TMO_W    = tmo_width(ACK_TIMEOUT);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);

  state_t             r_state;
  logic [7:0]         r_dado;
  logic [c_TMO_W-1:0] r_tmo;

  // The strobe follows the live busy flag so the UART sees it in the first
  // START cycle in which it is free.
  assign iniciar_envio = (r_state == ST_START) && !uart_ocupado;
  assign byte_done     = (r_state == ST_WAIT_DONE) && !uart_ocupado;
  assign dado_saida    = r_dado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dado  <= 8'h00;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_dado  <= byte_in;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (!uart_ocupado) begin
            r_tmo   <= '0;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (uart_ocupado) begin
            r_state <= ST_WAIT_DONE;
          end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
            if (r_tmo == c_TMO_LAST) begin
              r_state <= ST_START;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_ocupado) begin
            // Chaining the next byte here gives the two-cycle byte gap.
            if (go) begin
              r_dado  <= byte_in;
              r_state <= ST_START;
            end else begin
              r_dado  <= 8'h00;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/framed_payload_sender.sv
`default_nettype none
// ============================================================================
// Module   : framed_payload_sender
// Brief    : Sends EVENT_CODE, a latched payload and an optional XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module framed_payload_sender
  import framed_payload_sender_pkg::*;
#(
  parameter logic [7:0] EVENT_CODE     = 8'hAE,
  parameter int         SEND_BYTES_QTD = 2,
  parameter int         MSB_FIRST      = 1,
  parameter int         CHECKSUM_EN    = 1,
  parameter int         ACK_TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  framed_payload_sender_if.slave  bus
);

  localparam int                 c_TOTAL = 1 + SEND_BYTES_QTD + ((CHECKSUM_EN != 0) ? 1 : 0);
  localparam int                 c_IDX_W = idx_width(c_TOTAL);
  localparam int                 c_PW    = 8 * SEND_BYTES_QTD;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_TOTAL - 1);

  state_t             r_state;
  logic               r_armed;
  logic [c_PW-1:0]    r_payload;
  logic [c_IDX_W-1:0] r_k;
  logic [7:0]         r_cks;
  logic               r_concluido;
  logic               r_ocupado;

  logic               w_accept;
  logic               w_byte_done;
  logic               w_is_payload;
  logic               w_go;
  logic [c_IDX_W-1:0] w_k_next;
  logic [7:0]         w_cur_byte;
  logic [7:0]         w_cks_next;
  logic [7:0]         w_go_byte;
  logic               w_iniciar;
  logic [7:0]         w_dado;

  // Frame byte k: event code, payload in configured order, then checksum.
  function automatic logic [7:0] byte_at(input logic [c_IDX_W-1:0] k,
                                         input logic [7:0]         cks,
                                         input logic [c_PW-1:0]    payload);
    logic [7:0] b;
    b = 8'h00;
    if (k == '0) begin
      b = EVENT_CODE;
    end else if ((CHECKSUM_EN != 0) && (k == c_LAST)) begin
      b = cks;
    end else begin
      for (int i = 0; i < SEND_BYTES_QTD; i++) begin
        if (k == c_IDX_W'((MSB_FIRST != 0) ? (SEND_BYTES_QTD - i) : (i + 1))) begin
          b = payload[8*i +: 8];
        end
      end
    end
    return b;
  endfunction

  assign w_accept     = (r_state == ST_IDLE) && bus.habilitar_envio && r_armed;
  assign w_k_next     = r_k + c_IDX_W'(1);
  assign w_cur_byte   = byte_at(r_k, r_cks, r_payload);
  assign w_is_payload = (r_k != '0) && !((CHECKSUM_EN != 0) && (r_k == c_LAST));
  assign w_cks_next   = w_is_payload ? (r_cks ^ w_cur_byte) : r_cks;
  // The checksum byte is selected with the running XOR already including the
  // payload byte that is finishing in this same cycle.
  assign w_go         = w_accept || (w_byte_done && (r_state == ST_START) && (r_k != c_LAST));
  assign w_go_byte    = w_accept ? EVENT_CODE : byte_at(w_k_next, w_cks_next, r_payload);

  framed_payload_sender_uart_byte_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_handshake (
    .clock         (clock),
    .reset         (reset),
    .go            (w_go),
    .byte_in       (w_go_byte),
    .uart_ocupado  (bus.uart_ocupado),
    .iniciar_envio (w_iniciar),
    .dado_saida    (w_dado),
    .byte_done     (w_byte_done)
  );

  assign bus.iniciar_envio   = w_iniciar;
  assign bus.dado_saida      = w_dado;
  assign bus.envio_concluido = r_concluido;
  assign bus.ocupado         = r_ocupado;

  // ST_START spans the whole byte sequence; per-byte phases live in the
  // handshake block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b1;
      r_payload   <= '0;
      r_k         <= '0;
      r_cks       <= 8'h00;
      r_concluido <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      if (!bus.habilitar_envio) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_payload <= bus.buffer_envio;
            r_cks     <= EVENT_CODE;
            r_k       <= '0;
            r_ocupado <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_byte_done) begin
            r_cks <= w_cks_next;
            if (r_k == c_LAST) begin
              r_concluido <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_k <= w_k_next;
            end
          end
        end
        ST_DONE: begin
          r_concluido <= 1'b0;
          r_ocupado   <= 1'b0;
          r_k         <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_framed_payload_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_framed_payload_sender
// Brief    : Three sender configurations driven in parallel with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framed_payload_sender;

  logic        clock = 1'b0;
  logic        reset;
  logic        hab;
  logic [15:0] payload;
  logic [2:0]  busy;

  always #5 clock = ~clock;

  // dut 0: MSB first + checksum, short timeout; dut 1: LSB first + checksum;
  // dut 2: LSB first, no checksum.
  framed_payload_sender_if #(.SEND_BYTES_QTD(2)) if_a ();
  framed_payload_sender_if #(.SEND_BYTES_QTD(2)) if_b ();
  framed_payload_sender_if #(.SEND_BYTES_QTD(2)) if_c ();

  assign if_a.habilitar_envio = hab;
  assign if_b.habilitar_envio = hab;
  assign if_c.habilitar_envio = hab;
  assign if_a.buffer_envio    = payload;
  assign if_b.buffer_envio    = payload;
  assign if_c.buffer_envio    = payload;
  assign if_a.uart_ocupado    = busy[0];
  assign if_b.uart_ocupado    = busy[1];
  assign if_c.uart_ocupado    = busy[2];

  framed_payload_sender #(.EVENT_CODE(8'hAE), .SEND_BYTES_QTD(2), .MSB_FIRST(1),
                          .CHECKSUM_EN(1), .ACK_TIMEOUT(8))
    dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
  framed_payload_sender #(.EVENT_CODE(8'hAE), .SEND_BYTES_QTD(2), .MSB_FIRST(0),
                          .CHECKSUM_EN(1), .ACK_TIMEOUT(255))
    dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));
  framed_payload_sender #(.EVENT_CODE(8'hAE), .SEND_BYTES_QTD(2), .MSB_FIRST(0),
                          .CHECKSUM_EN(0), .ACK_TIMEOUT(255))
    dut_c (.clock(clock), .reset(reset), .bus(if_c.slave));

  logic [2:0] strb, concl, ocup;
  logic [7:0] dat [3];
  assign strb   = {if_c.iniciar_envio, if_b.iniciar_envio, if_a.iniciar_envio};
  assign concl  = {if_c.envio_concluido, if_b.envio_concluido, if_a.envio_concluido};
  assign ocup   = {if_c.ocupado, if_b.ocupado, if_a.ocupado};
  assign dat[0] = if_a.dado_saida;
  assign dat[1] = if_b.dado_saida;
  assign dat[2] = if_c.dado_saida;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  cks;
  } vec_t;

  vec_t       vecs [5];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         busy_cnt [3];
  int         done_cnt [3];
  int         exp_done [3];
  int         strobe_cnt [3];
  logic [2:0] pend;
  int         ignore_a;
  logic       log_a;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int         a_cyc [$];
  logic [7:0] a_dat [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [7:0] b);
    case (d)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    case (d)
      0:       if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic push_frame(input logic [15:0] p, input logic [7:0] cks);
    for (int d = 0; d < 3; d++) begin
      push_exp(d, 8'hAE);
      if (d == 0) begin
        push_exp(d, p[15:8]);
        push_exp(d, p[7:0]);
      end else begin
        push_exp(d, p[7:0]);
        push_exp(d, p[15:8]);
      end
      if (d != 2) push_exp(d, cks);
      exp_done[d]++;
    end
  endtask

  // One clock: UART model reacts after the edge, outputs checked at negedge.
  task automatic step();
    logic [7:0] e;
    bit         ok;
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (pend[d]) begin
        busy[d]     = 1'b1;
        busy_cnt[d] = 10;
        pend[d]     = 1'b0;
      end else if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
        if (busy_cnt[d] == 0) busy[d] = 1'b0;
      end
    end
    @(negedge clock);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (concl[d]) begin
        done_cnt[d]++;
        chk($sformatf("concl_ocupado_dut%0d", d), {31'd0, ocup[d]}, 32'd1);
        chk($sformatf("concl_dado_zero_dut%0d", d), {24'd0, dat[d]}, 32'd0);
      end
      if (strb[d]) begin
        strobe_cnt[d]++;
        if (d == 0 && log_a) begin
          a_cyc.push_back(cyc);
          a_dat.push_back(dat[0]);
        end
        if (d == 0 && ignore_a > 0) begin
          ignore_a--;
        end else begin
          pop_exp(d, e, ok);
          if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_dut%0d: got unexpected byte 'h%0h, expected no strobe", d, dat[d]);
          end else begin
            chk($sformatf("byte_dut%0d", d), {24'd0, dat[d]}, {24'd0, e});
          end
          pend[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_all();
    int n;
    n = 0;
    while (((done_cnt[0] < exp_done[0]) || (done_cnt[1] < exp_done[1]) ||
            (done_cnt[2] < exp_done[2])) && (n < 800)) begin
      step();
      n++;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("frame_count_dut%0d", d), done_cnt[d], exp_done[d]);
      chk($sformatf("ocupado_idle_dut%0d", d), {31'd0, ocup[d]}, 32'd0);
    end
    chk("queue_left_dut0", q0.size(), 0);
    chk("queue_left_dut1", q1.size(), 0);
    chk("queue_left_dut2", q2.size(), 0);
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while ((strobe_cnt[0] < target) && (n < 400)) begin
      step();
      n++;
    end
    chk("strobe_reached", {31'd0, strobe_cnt[0] >= target}, 32'd1);
  endtask

  task automatic start_frame(input logic [15:0] p, input logic [7:0] cks);
    payload = p;
    push_frame(p, cks);
    hab = 1'b1;
    step();
    hab = 1'b0;
  endtask

  initial begin
    int base;
    vecs[0] = '{16'h1234, 8'h88};
    vecs[1] = '{16'h0000, 8'hAE};
    vecs[2] = '{16'hFFFF, 8'hAE};
    vecs[3] = '{16'hAE00, 8'h00};
    vecs[4] = '{16'h5A3C, 8'hC8};

    reset    = 1'b0;
    hab      = 1'b0;
    payload  = 16'h0000;
    busy     = 3'b000;
    pend     = 3'b000;
    ignore_a = 0;
    log_a    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      busy_cnt[d]   = 0;
      done_cnt[d]   = 0;
      exp_done[d]   = 0;
      strobe_cnt[d] = 0;
    end

    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_strobe_dut%0d", d), {31'd0, strb[d]}, 32'd0);
      chk($sformatf("reset_dado_dut%0d", d), {24'd0, dat[d]}, 32'd0);
      chk($sformatf("reset_concl_dut%0d", d), {31'd0, concl[d]}, 32'd0);
      chk($sformatf("reset_ocupado_dut%0d", d), {31'd0, ocup[d]}, 32'd0);
    end
    reset = 1'b1;
    repeat (2) step();

    // Byte order and checksum over a table of payloads.
    for (int i = 0; i < 5; i++) begin
      start_frame(vecs[i].data, vecs[i].cks);
      wait_all();
    end

    // Held request gives a single frame; one low cycle re-arms.
    payload = 16'h5A3C;
    push_frame(16'h5A3C, 8'hC8);
    hab = 1'b1;
    repeat (200) step();
    hab = 1'b0;
    step();
    payload = 16'h0000;
    push_frame(16'h0000, 8'hAE);
    hab = 1'b1;
    step();
    hab = 1'b0;
    wait_all();

    // Payload change after acceptance does not leak into the frame.
    base = strobe_cnt[0];
    start_frame(16'h1234, 8'h88);
    wait_strobes(base + 2);
    payload = 16'hFFFF;
    wait_all();

    // First strobe ignored by the UART: retry after the ack timeout.
    a_cyc.delete();
    a_dat.delete();
    ignore_a = 1;
    log_a    = 1'b1;
    start_frame(16'h1234, 8'h88);
    wait_all();
    log_a = 1'b0;
    chk("retry_strobe_count", a_cyc.size(), 5);
    if (a_cyc.size() >= 2) begin
      chk("retry_gap", a_cyc[1] - a_cyc[0], 9);
      chk("retry_first_byte", {24'd0, a_dat[0]}, 32'hAE);
      chk("retry_second_byte", {24'd0, a_dat[1]}, 32'hAE);
    end

    // Reset in the middle of byte 2 aborts all frames without completion.
    base = strobe_cnt[0];
    start_frame(16'h1234, 8'h88);
    wait_strobes(base + 3);
    repeat (3) step();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_strobe_dut%0d", d), {31'd0, strb[d]}, 32'd0);
      chk($sformatf("abort_dado_dut%0d", d), {24'd0, dat[d]}, 32'd0);
      chk($sformatf("abort_concl_dut%0d", d), {31'd0, concl[d]}, 32'd0);
      chk($sformatf("abort_ocupado_dut%0d", d), {31'd0, ocup[d]}, 32'd0);
      busy_cnt[d] = 0;
      exp_done[d]--;
    end
    busy = 3'b000;
    pend = 3'b000;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_no_done_dut%0d", d), done_cnt[d], exp_done[d]);
    end
    reset = 1'b1;
    step();
    start_frame(16'h1234, 8'h88);
    wait_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
